dqt_segment_writer: RTL and testbench

Encoder-side counterpart of the DQT decoding stage. Holds up to four 8-bit quantization tables loaded in natural (raster) order and, on command, emits one complete JPEG DQT marker segment as a byte stream. Each selected table is written in zigzag order. Sits between the table-configuration logic and the JPEG byte-stream assembler, ahead of SOF/DHT emission.

---
 rtl/dqt_segment_writer_if.sv | 30 +++
 rtl/dqt_segment_writer.sv | 169 ++++++++++++++++
 tb/tb_dqt_segment_writer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dqt_segment_writer_if.sv
// rtl/dqt_segment_writer_if.sv - byte-stream handshake bundle for the DQT segment writer
//
// Purpose: carries the emitted segment bytes from the writer to the byte-stream assembler.
// Signals:
//   out_data   8  segment byte
//   out_valid  1  out_data valid
//   out_last   1  final byte of the segment
//   out_ready  1  sink accepts the byte (handshake = out_valid && out_ready)
// Modports: master drives the byte stream, slave consumes it.

interface dqt_segment_writer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/dqt_segment_writer.sv
// rtl/dqt_segment_writer.sv - JPEG DQT marker segment emitter with four 8-bit tables
//
// Purpose: stores four 64-entry quantization tables in natural order and, on start,
// emits FF DB Lq followed by {Pq,Tq} + 64 zigzag-ordered bytes per selected table.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en/wr_tid/wr_idx/wr_data  table load (natural index), accepted only when not busy
//   start, table_mask   begin a segment with the selected tables, sampled only in idle
//   out_if              byte stream (master side): out_data/out_valid/out_last/out_ready
//   busy                segment in progress
//   done                one-cycle completion pulse

module dqt_segment_writer (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [1:0]                  wr_tid,
  input  logic [5:0]                  wr_idx,
  input  logic [7:0]                  wr_data,
  input  logic                        start,
  input  logic [3:0]                  table_mask,
  dqt_segment_writer_if.master        out_if,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_MARK_FF, S_MARK_DB, S_LEN_HI, S_LEN_LO, S_PQTQ, S_DATA, S_DONE
  } state_t;

  // Zigzag position k -> natural (raster) index.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_t     state_q;
  logic [7:0] mem [4][64];
  logic [3:0] rem_q;
  logic [5:0] k_q;
  logic [7:0] out_data_q;
  logic       out_valid_q;
  logic       out_last_q;
  logic       busy_q;
  logic       done_q;

  logic [1:0]  cur_t;
  logic [3:0]  rem_d;
  logic [1:0]  nxt_t;
  logic [15:0] lq;
  logic [5:0]  k_d;
  logic        fire;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_comb begin
    cur_t = lowest_set(rem_q);
    // Mask with the current table retired; decides PQTQ-next vs DONE and out_last.
    rem_d = rem_q & ~(4'b0001 << cur_t);
    nxt_t = lowest_set(rem_d);
    // rem_q still holds the full mask while the length bytes are emitted.
    lq    = 16'd2 + 16'd65 * ({15'd0, rem_q[0]} + {15'd0, rem_q[1]} +
                              {15'd0, rem_q[2]} + {15'd0, rem_q[3]});
    k_d   = k_q + 6'd1;
    fire  = out_valid_q && out_if.out_ready;
  end

  // Tables are retained across rst; writes are locked out while a segment runs.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE || state_q == S_DONE)) begin
      mem[wr_tid][wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= 4'd0;
      k_q         <= 6'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q <= table_mask;
            k_q   <= 6'd0;
            if (table_mask != 4'd0) begin
              state_q     <= S_MARK_FF;
              out_data_q  <= 8'hFF;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_MARK_FF: if (fire) begin
          state_q    <= S_MARK_DB;
          out_data_q <= 8'hDB;
        end
        S_MARK_DB: if (fire) begin
          state_q    <= S_LEN_HI;
          out_data_q <= lq[15:8];
        end
        S_LEN_HI: if (fire) begin
          state_q    <= S_LEN_LO;
          out_data_q <= lq[7:0];
        end
        S_LEN_LO: if (fire) begin
          state_q    <= S_PQTQ;
          out_data_q <= {6'd0, cur_t};
        end
        S_PQTQ: if (fire) begin
          state_q    <= S_DATA;
          k_q        <= 6'd0;
          out_data_q <= mem[cur_t][ZZ[0]];
          out_last_q <= 1'b0;
        end
        S_DATA: if (fire) begin
          if (k_q == 6'd63) begin
            rem_q      <= rem_d;
            out_last_q <= 1'b0;
            if (rem_d != 4'd0) begin
              state_q    <= S_PQTQ;
              k_q        <= 6'd0;
              out_data_q <= {6'd0, nxt_t};
            end else begin
              state_q     <= S_DONE;
              out_data_q  <= 8'h00;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end else begin
            k_q        <= k_d;
            out_data_q <= mem[cur_t][ZZ[k_d]];
            out_last_q <= (k_d == 6'd63) && (rem_d == 4'd0);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_dqt_segment_writer.sv
// tb/tb_dqt_segment_writer.sv - scoreboard bench for the DQT segment writer

module tb_dqt_segment_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_tid;
  logic [5:0] wr_idx;
  logic [7:0] wr_data;
  logic       start;
  logic [3:0] table_mask;
  logic       busy;
  logic       done;

  dqt_segment_writer_if bus ();

  dqt_segment_writer dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_tid     (wr_tid),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .start      (start),
    .table_mask (table_mask),
    .out_if     (bus),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  localparam int ZZ [64] = '{
    0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  int         tests = 0;
  int         fails = 0;
  logic [8:0] exp_q [$];
  logic [7:0] cap_q [$];
  logic [7:0] ref_q [$];
  logic [7:0] tb_mem [4][64];
  int         done_count   = 0;
  int         hs_count     = 0;
  int         valid_cycles = 0;
  bit         expect_done  = 1'b0;
  bit         rand_ready   = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_segment(input logic [3:0] m);
    int          n;
    int          last_t;
    logic [15:0] lq;
    n  = int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    lq = 16'(2 + 65 * n);
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'hDB});
    exp_q.push_back({1'b0, lq[15:8]});
    exp_q.push_back({1'b0, lq[7:0]});
    last_t = -1;
    for (int t = 0; t < 4; t++) if (m[t]) last_t = t;
    for (int t = 0; t < 4; t++) begin
      if (m[t]) begin
        exp_q.push_back({1'b0, 8'(t)});
        for (int k = 0; k < 64; k++)
          exp_q.push_back({(t == last_t && k == 63), tb_mem[t][ZZ[k]]});
      end
    end
  endtask

  task automatic write_mem(input int t, input int idx, input logic [7:0] v);
    wr_en   = 1'b1;
    wr_tid  = 2'(t);
    wr_idx  = 6'(idx);
    wr_data = v;
    tb_mem[t][idx] = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_seg(input logic [3:0] m);
    start      = 1'b1;
    table_mask = m;
    tick();
    start      = 1'b0;
    table_mask = 4'h0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check_eq({name, "_drain_left"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic monitor();
    bit         stall_prev;
    logic [7:0] pd;
    logic       pl;
    logic [8:0] e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        check_eq("stall_data_hold", bus.out_data, pd);
        check_eq("stall_last_hold", bus.out_last, pl);
      end
      if (expect_done) begin
        check_eq("done_busy_valid_after_last", {done, busy, bus.out_valid}, 3'b100);
        expect_done = 1'b0;
      end
      if (done) done_count++;
      if (bus.out_valid) valid_cycles++;
      if (bus.out_valid && bus.out_ready && !rst) begin
        hs_count++;
        cap_q.push_back(bus.out_data);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got 0x%0h, expected no byte", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check_eq($sformatf("seg_byte_%0d", cap_q.size()), {bus.out_last, bus.out_data}, e);
        end
        if (bus.out_last) expect_done = 1'b1;
      end
      stall_prev = bus.out_valid && !bus.out_ready && !rst;
      pd = bus.out_data;
      pl = bus.out_last;
    end
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         h0;
    int         d0;
    int         v0;
    int         diffs;
    logic [7:0] lit [12];
    lit = '{8'hFF, 8'hDB, 8'h00, 8'h43, 8'h00, 8'h01, 8'h02, 8'h09,
            8'h11, 8'h0A, 8'h03, 8'h04};

    rst = 1'b1; wr_en = 1'b0; wr_tid = 2'd0; wr_idx = 6'd0; wr_data = 8'd0;
    start = 1'b0; table_mask = 4'd0; bus.out_ready = 1'b1;
    fork
      monitor();
      ready_gen();
    join_none

    repeat (3) tick();
    @(negedge clk);
    check_eq("reset_outputs", {bus.out_valid, bus.out_last, bus.out_data, busy, done}, 12'h000);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 64; i++) write_mem(0, i, 8'(i + 1));
    for (int i = 0; i < 64; i++) write_mem(1, i, 8'(8'h80 + i));
    for (int i = 0; i < 64; i++) write_mem(2, i, 8'(8'h20 ^ (i * 3)));
    for (int i = 0; i < 64; i++) write_mem(3, i, 8'(8'h80 + i));

    // One table, ready held high
    cap_q.delete();
    push_segment(4'b0001);
    h0 = hs_count; d0 = done_count; v0 = valid_cycles;
    start_seg(4'b0001);
    @(negedge clk);
    check_eq("start_latency", {bus.out_valid, busy, bus.out_data}, {1'b1, 1'b1, 8'hFF});
    wait_drain(400, "one_table");
    check_eq("one_table_bytes", hs_count - h0, 69);
    check_eq("one_table_valid_cycles", valid_cycles - v0, 69);
    check_eq("one_table_done_count", done_count - d0, 1);
    for (int i = 0; i < 12; i++)
      if (cap_q.size() > i) check_eq($sformatf("one_table_literal_%0d", i), cap_q[i], lit[i]);
    if (cap_q.size() == 69) check_eq("one_table_final_byte", cap_q[68], 8'h40);

    // Tables 1 and 3
    cap_q.delete();
    push_segment(4'b1010);
    h0 = hs_count; d0 = done_count;
    start_seg(4'b1010);
    wait_drain(600, "two_table");
    check_eq("two_table_bytes", hs_count - h0, 134);
    check_eq("two_table_done_count", done_count - d0, 1);
    if (cap_q.size() == 134) begin
      check_eq("two_table_lq", {cap_q[2], cap_q[3]}, 16'h0084);
      check_eq("two_table_pqtq1", cap_q[4], 8'h01);
      check_eq("two_table_pqtq3", cap_q[69], 8'h03);
    end

    // Four tables, ready high then 50% random backpressure
    cap_q.delete();
    push_segment(4'b1111);
    start_seg(4'b1111);
    wait_drain(1000, "four_table_ref");
    check_eq("four_table_ref_bytes", cap_q.size(), 264);
    ref_q = cap_q;
    cap_q.delete();
    push_segment(4'b1111);
    d0 = done_count;
    rand_ready = 1'b1;
    start_seg(4'b1111);
    wait_drain(3000, "four_table_bp");
    rand_ready = 1'b0;
    check_eq("four_table_bp_bytes", cap_q.size(), 264);
    check_eq("four_table_bp_done_count", done_count - d0, 1);
    diffs = 0;
    for (int i = 0; i < 264; i++)
      if (i < cap_q.size() && i < ref_q.size() && cap_q[i] !== ref_q[i]) diffs++;
    check_eq("four_table_bp_stream_diffs", diffs, 0);
    if (ref_q.size() == 264) check_eq("four_table_lq", {ref_q[2], ref_q[3]}, 16'h0106);

    // Start and table write while busy must be ignored
    cap_q.delete();
    push_segment(4'b0001);
    h0 = hs_count; d0 = done_count;
    start_seg(4'b0001);
    repeat (5) tick();
    start = 1'b1; table_mask = 4'b1111;
    wr_en = 1'b1; wr_tid = 2'd0; wr_idx = 6'd0; wr_data = 8'hEE;
    tick();
    start = 1'b0; table_mask = 4'd0; wr_en = 1'b0;
    wait_drain(400, "busy_reject");
    repeat (10) tick();
    check_eq("busy_reject_bytes", hs_count - h0, 69);
    check_eq("busy_reject_done_count", done_count - d0, 1);

    // Reset mid-segment at byte 30
    push_segment(4'b0001);
    h0 = hs_count;
    start_seg(4'b0001);
    for (int i = 0; i < 200 && (hs_count - h0) < 30; i++) @(negedge clk);
    check_eq("midreset_reached_byte30", hs_count - h0, 30);
    @(posedge clk);
    #1;
    rst = 1'b1;
    d0 = done_count;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("midreset_outputs", {bus.out_valid, bus.out_last, bus.out_data, busy, done}, 12'h000);
    exp_q.delete();
    repeat (5) tick();
    check_eq("midreset_no_done", done_count - d0, 0);
    cap_q.delete();
    push_segment(4'b0001);
    h0 = hs_count; d0 = done_count;
    start_seg(4'b0001);
    wait_drain(400, "after_reset");
    check_eq("after_reset_bytes", hs_count - h0, 69);
    check_eq("after_reset_done_count", done_count - d0, 1);

    // Empty mask: no bytes, done at N+1
    h0 = hs_count; v0 = valid_cycles;
    start_seg(4'b0000);
    @(negedge clk);
    check_eq("mask0_n1", {done, busy, bus.out_valid}, 3'b100);
    @(negedge clk);
    check_eq("mask0_n2", {done, busy, bus.out_valid}, 3'b000);
    repeat (3) tick();
    check_eq("mask0_no_bytes", hs_count - h0, 0);
    check_eq("mask0_no_valid", valid_cycles - v0, 0);

    // Write and start on the same idle edge: segment sees the new value
    tb_mem[1][0] = 8'h55;
    push_segment(4'b0010);
    h0 = hs_count;
    start = 1'b1; table_mask = 4'b0010;
    wr_en = 1'b1; wr_tid = 2'd1; wr_idx = 6'd0; wr_data = 8'h55;
    tick();
    start = 1'b0; table_mask = 4'd0; wr_en = 1'b0;
    wait_drain(400, "write_with_start");
    check_eq("write_with_start_bytes", hs_count - h0, 69);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
